// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex glyph table (bit 6 = segment a ... bit 0 = segment g) and the
// all-off pattern used for blanked digits.
package ssd_pkg;

   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F = 1;
   localparam int unsigned SEG_G = 0;

   localparam logic [6:0] BLANK_SEG = 7'b0000000;

   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'b1111110,  // 0
      7'b0110000,  // 1
      7'b1101101,  // 2
      7'b1111001,  // 3
      7'b0110011,  // 4
      7'b1011011,  // 5
      7'b1011111,  // 6
      7'b1110000,  // 7
      7'b1111111,  // 8
      7'b1111011,  // 9
      7'b1110111,  // A
      7'b0011111,  // b
      7'b1001110,  // C
      7'b0111101,  // d
      7'b1001111,  // E
      7'b1000111   // F
   };

   // Segment pattern for one hex nibble.
   function automatic logic [6:0] glyph(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seven_segment_glyph.sv
// Combinational nibble-to-segment encoder with a blank override.
module seven_segment_glyph
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   // Blanked digits show nothing; otherwise the table glyph.
   always_comb begin
      seg = glyph(nibble);
      if (blank) seg = BLANK_SEG;
   end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver.
// A prescaler paces the digit scan; a new value is staged on load and copied
// into the displayed (shadow) copy only when the scan wraps to digit 0, so a
// frame never mixes old and new digits.
// Optional build macro SSD_DP_EN adds a per-digit decimal point (dp_mask in,
// dp out) that follows the same staging/apply rules as value.
//
// Handshake: load is a level-sampled request with no back-pressure; every
// cycle with load high captures value (last one wins). load_ack is a single
// cycle pulse, the cycle after the frame boundary at which the captured value
// became the displayed value. A reset discards any staged value without ack.
module seven_segment_scan_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic                    en,
`ifdef SSD_DP_EN
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic                    dp,
`endif
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    load_ack
);

   localparam int VW = 4 * NUM_DIGITS;
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc;
   logic [IW-1:0]         dig_idx;
   logic [VW-1:0]         staging;
   logic [VW-1:0]         shadow;
   logic                  pending;

   logic                  tick;
   logic                  boundary;
   logic                  apply;
   logic [IW-1:0]         next_idx;
   logic [VW-1:0]         apply_value;
   logic [VW-1:0]         next_shadow;
   logic [3:0]            nibble;
   logic [NUM_DIGITS-1:0] upper_zero;
   logic                  lz_run;
   logic                  blank;
   logic [6:0]            glyph_seg;
   logic [NUM_DIGITS-1:0] an_next;

   // Scan timing and apply decision; outputs are computed from the index and
   // shadow value that will hold after this edge so anode and segments move together.
   always_comb begin
      tick        = (presc == PRESC_LAST);
      boundary    = tick && (dig_idx == IDX_LAST);
      apply       = boundary && (pending || load);
      apply_value = load ? value : staging;
      next_shadow = apply ? apply_value : shadow;
      next_idx    = dig_idx;
      if (tick) next_idx = (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
   end

   // Digit nibble select and leading-zero detection from the top digit down.
   always_comb begin
      nibble     = '0;
      upper_zero = '0;
      lz_run     = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run        = lz_run && (next_shadow[i*4 +: 4] == 4'h0);
         upper_zero[i] = lz_run;
         if (IW'(i) == next_idx) nibble = next_shadow[i*4 +: 4];
      end
      blank   = blank_lz && (next_idx != '0) && upper_zero[next_idx];
      an_next = en ? (NUM_DIGITS'(1) << next_idx) : '0;
   end

   seven_segment_glyph u_glyph (
      .nibble (nibble),
      .blank  (blank),
      .seg    (glyph_seg)
   );

   // Prescaler: counts 0..REFRESH_DIV-1 and wraps on tick.
   always_ff @(posedge clk) begin
      if (reset || tick) presc <= '0;
      else               presc <= presc + 1'b1;
   end

   // Scan index advances one digit per tick.
   always_ff @(posedge clk) begin
      if (reset) dig_idx <= '0;
      else       dig_idx <= next_idx;
   end

   // Staging/shadow update: latest load wins, applied only at the frame boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         staging  <= '0;
         shadow   <= '0;
         pending  <= 1'b0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= apply;
         if (load) staging <= value;
         if (apply) begin
            shadow  <= apply_value;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   // Registered segment and anode outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= BLANK_SEG;
         an  <= '0;
      end else begin
         seg <= glyph_seg;
         an  <= an_next;
      end
   end

`ifdef SSD_DP_EN
   logic [NUM_DIGITS-1:0] staging_dp;
   logic [NUM_DIGITS-1:0] shadow_dp;
   logic [NUM_DIGITS-1:0] next_shadow_dp;

   // Decimal-point shadow that will hold after this edge.
   always_comb begin
      next_shadow_dp = shadow_dp;
      if (apply) next_shadow_dp = load ? dp_mask : staging_dp;
   end

   // Decimal-point staging/shadow and registered output; never blanked.
   always_ff @(posedge clk) begin
      if (reset) begin
         staging_dp <= '0;
         shadow_dp  <= '0;
         dp         <= 1'b0;
      end else begin
         if (load) staging_dp <= dp_mask;
         shadow_dp <= next_shadow_dp;
         dp        <= next_shadow_dp[next_idx];
      end
   end
`endif

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench for seven_segment_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Edge numbering: cyc counts rising edges since reset release; outputs are
// sampled 1 time unit after each edge. Digit i is lit after edges 4k..4k+3
// with i = k mod 4; edges 16, 32, 48, ... are frame boundaries.
module tb_seven_segment_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic        load;
   logic        blank_lz;
   logic        en;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        load_ack;
`ifdef SSD_DP_EN
   logic [3:0]  dp_mask;
   logic        dp;
`endif

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int ack_count = 0;

   seven_segment_scan_driver #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .value    (value),
      .load     (load),
      .blank_lz (blank_lz),
      .en       (en),
`ifdef SSD_DP_EN
      .dp_mask  (dp_mask),
      .dp       (dp),
`endif
      .seg      (seg),
      .an       (an),
      .load_ack (load_ack)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (load_ack === 1'b1) ack_count++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   // Directed sequence.
   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      value    = '0;
      blank_lz = 1'b0;
      en       = 1'b1;
`ifdef SSD_DP_EN
      dp_mask  = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_seg", seg, 7'b0000000);
      check("rst_an", an, 4'b0000);
      check("rst_ack", load_ack, 1'b0);
`ifdef SSD_DP_EN
      check("rst_dp", dp, 1'b0);
`endif
      reset = 1'b0;
      cyc   = 0;

      // 1. Scan rotation after reset.
      step();
      check("t1_an_first", an, 4'b0001);
      check("t1_seg_first", seg, 7'b1111110);
      run_to(3);
      check("t1_an_hold", an, 4'b0001);
      run_to(4);
      check("t1_an_d1", an, 4'b0010);
      check("t1_seg_d1", seg, 7'b1111110);
      run_to(8);
      check("t1_an_d2", an, 4'b0100);
      run_to(12);
      check("t1_an_d3", an, 4'b1000);
      run_to(16);
      check("t1_an_wrap", an, 4'b0001);

      // 2. Mid-frame load of 1234, applied at the next boundary (edge 32).
      run_to(17);
      ack_count = 0;
      value     = 16'h1234;
      load      = 1'b1;
`ifdef SSD_DP_EN
      dp_mask   = 4'b0101;
`endif
      step();
      load  = 1'b0;
      value = 16'h0000;
`ifdef SSD_DP_EN
      dp_mask = 4'b0000;
`endif
      run_to(28);
      check("t2_old_an", an, 4'b1000);
      check("t2_old_seg", seg, 7'b1111110);
      run_to(31);
      check("t2_no_early_ack", ack_count, 0);
      run_to(32);
      check("t2_ack", load_ack, 1'b1);
      check("t2_an0", an, 4'b0001);
      check("t2_dig0", seg, 7'b0110011);
`ifdef SSD_DP_EN
      check("t2_dp0", dp, 1'b1);
`endif
      step();
      check("t2_ack_end", load_ack, 1'b0);
      run_to(36);
      check("t2_dig1", seg, 7'b1111001);
`ifdef SSD_DP_EN
      check("t2_dp1", dp, 1'b0);
`endif
      run_to(40);
      check("t2_dig2", seg, 7'b1101101);
      run_to(44);
      check("t2_an3", an, 4'b1000);
      check("t2_dig3", seg, 7'b0110000);
      check("t2_ack_count", ack_count, 1);

      // 3. Two loads in one frame, last wins; leading-zero blanking on.
      blank_lz  = 1'b1;
      ack_count = 0;
      value     = 16'hAAAA;
      load      = 1'b1;
      step();
      value = 16'h00F0;
      step();
      load  = 1'b0;
      value = 16'h0000;
      run_to(47);
      check("t3_pre_dig3", seg, 7'b0110000);
      run_to(48);
      check("t3_dig0", seg, 7'b1111110);
      run_to(52);
      check("t3_dig1", seg, 7'b1000111);
      run_to(56);
      check("t3_an2", an, 4'b0100);
      check("t3_dig2_blank", seg, 7'b0000000);
      run_to(60);
      check("t3_dig3_blank", seg, 7'b0000000);
      check("t3_ack_count", ack_count, 1);

      // 4. Load coincident with the wrap tick (edge 64).
      run_to(63);
      ack_count = 0;
      value     = 16'h8888;
      load      = 1'b1;
      step();
      load  = 1'b0;
      value = 16'h0000;
      check("t4_an0", an, 4'b0001);
      check("t4_dig0", seg, 7'b1111111);
      check("t4_ack", load_ack, 1'b1);
      step();
      check("t4_ack_end", load_ack, 1'b0);
      check("t4_ack_count", ack_count, 1);

      // 5. Display disabled for 10 cycles with a load issued meanwhile.
      run_to(66);
      en        = 1'b0;
      ack_count = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("t5_an_off", an, 4'b0000);
         if (cyc == 68) begin
            value = 16'h0005;
            load  = 1'b1;
         end else if (cyc == 69) begin
            load  = 1'b0;
            value = 16'h0000;
         end
      end
      en = 1'b1;
      step();
      check("t5_an_back", an, 4'b1000);
      run_to(80);
      check("t5_an0", an, 4'b0001);
      check("t5_dig0", seg, 7'b1011011);
      check("t5_ack", load_ack, 1'b1);
      run_to(84);
      check("t5_an1", an, 4'b0010);
      check("t5_dig1_blank", seg, 7'b0000000);
      check("t5_ack_count", ack_count, 1);

      // 6. Reset mid-frame with a load pending.
      run_to(86);
      value = 16'h4321;
      load  = 1'b1;
`ifdef SSD_DP_EN
      dp_mask = 4'b1111;
`endif
      step();
      load  = 1'b0;
      value = 16'h0000;
      run_to(89);
      reset = 1'b1;
      step();
      check("t6_rst_seg", seg, 7'b0000000);
      check("t6_rst_an", an, 4'b0000);
      check("t6_rst_ack", load_ack, 1'b0);
`ifdef SSD_DP_EN
      check("t6_rst_dp", dp, 1'b0);
`endif
      reset     = 1'b0;
      cyc       = 0;
      ack_count = 0;
      step();
      check("t6_an0", an, 4'b0001);
      check("t6_dig0", seg, 7'b1111110);
      run_to(4);
      check("t6_dig1_blank", seg, 7'b0000000);
      run_to(16);
      check("t6_wrap_an", an, 4'b0001);
      check("t6_wrap_seg", seg, 7'b1111110);
`ifdef SSD_DP_EN
      check("t6_wrap_dp", dp, 1'b0);
`endif
      run_to(20);
      check("t6_no_ack", ack_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
